// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and target state encoding
//
// Constants shared by the I2C target and the I2C master controller:
//   ADDR_WIDTH  7-bit addressing only
//   RW_BIT      bit index of R/W in the address byte (1 = read)
//   I2C_ACK     SDA level for acknowledge
//   I2C_NACK    SDA level for not-acknowledge
//   i2c_state_t target state machine encoding
package i2c_pkg;

    localparam int   ADDR_WIDTH = 7;
    localparam int   RW_BIT     = 0;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

endpackage

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - pin and core-side signals of the I2C target
//
// Pin side:  scl_in, sda_in (asynchronous pin levels), sda_oe (1 pulls SDA low)
// Core side: rx_data/rx_valid (written bytes), tx_data/tx_load (read bytes),
//            busy, start_det, stop_det status pulses/levels
// Modports:  slave  - the target itself
//            master - the environment driving the pins and the core side
interface i2c_target_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output tx_load,
        output busy,
        output start_det,
        output stop_det
    );

    modport master (
        output scl_in,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_load,
        input  busy,
        input  start_det,
        input  stop_det
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - pin synchroniser with history flop and edge decode
//
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous pin level
//   level     synchronised level
//   rise      one-cycle pulse when level goes 0->1
//   fall      one-cycle pulse when level goes 1->0
// All flops reset to 1 so an idle-high bus produces no edge after reset.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with fixed 7-bit address, read and write
//
// Ports:
//   clk           system clock, at least 16x the SCL frequency
//   rst           synchronous active-high reset
//   bus.scl_in    SCL pin level (asynchronous)
//   bus.sda_in    SDA pin level (asynchronous)
//   bus.sda_oe    1 pulls SDA low, 0 releases it; SCL is never driven
//   bus.rx_data   last byte written by the master, valid with rx_valid
//   bus.rx_valid  one-cycle pulse per received byte
//   bus.tx_data   byte to return on a read, captured while tx_load=1
//   bus.tx_load   one-cycle pulse requesting/capturing the next read byte
//   bus.busy      high from address match until STOP, mismatch or NACK
//   bus.start_det one-cycle pulse on START or repeated START
//   bus.stop_det  one-cycle pulse on STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       ack_seen;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_load_q;
    logic       busy_q;
    logic       start_det_q;
    logic       stop_det_q;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Both pins share the same synchroniser depth, so SDA edges are judged
    // against the SCL level that was present when SDA actually moved.
    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd7;
            shift       <= 8'h00;
            ack_seen    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            start_det_q <= start_c;
            stop_det_q  <= stop_c;

            if (stop_c) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd7;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                ack_seen <= 1'b0;
            end else if (start_c) begin
                // Any partial byte is dropped; the address phase restarts.
                state    <= ST_ADDR;
                bit_cnt  <= 3'd7;
                sda_oe_q <= 1'b0;
                ack_seen <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_lvl};
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                // shift[6:0] holds the seven address bits; the
                                // bit arriving now is R/W.
                                if (shift[6:0] == TARGET_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    busy_q <= 1'b1;
                                end else begin
                                    state  <= ST_WAIT_STOP;
                                    busy_q <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_WR_ACK: begin
                        // sda_oe doubles as the phase flag: the first fall opens
                        // the ACK slot, the second one closes it.
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (state == ST_ADDR_ACK && shift[RW_BIT]) begin
                                // Keep SDA low until the first data bit is known.
                                state     <= ST_RD_DATA;
                                bit_cnt   <= 3'd7;
                                tx_load_q <= 1'b1;
                            end else begin
                                state    <= ST_WR_DATA;
                                bit_cnt  <= 3'd7;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_lvl};
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                rx_data_q  <= {shift[6:0], sda_lvl};
                                rx_valid_q <= 1'b1;
                                state      <= ST_WR_ACK;
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (tx_load_q) begin
                            shift    <= bus.tx_data;
                            sda_oe_q <= ~bus.tx_data[7];
                        end else if (scl_fall) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                sda_oe_q <= 1'b0;
                                ack_seen <= 1'b0;
                                state    <= ST_RD_ACK;
                            end else begin
                                // Rotate rather than shift: the byte is reloaded
                                // from tx_data before it is sent again.
                                shift    <= {shift[6:0], shift[7]};
                                sda_oe_q <= ~shift[6];
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_NACK) begin
                                state  <= ST_WAIT_STOP;
                                busy_q <= 1'b0;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            ack_seen  <= 1'b0;
                            state     <= ST_RD_DATA;
                            bit_cnt   <= 3'd7;
                            tx_load_q <= 1'b1;
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP only react to START/STOP.
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.busy      = busy_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] b0;
        logic [7:0] b1;
        int         n;
        logic       exp_ack;
        int         exp_rx;
        int         exp_txl;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;
    logic mon_en = 1'b1;
    logic [7:0] tx_arr [4];
    int   tx_base = 0;
    int   tx_done = 0;
    logic [1:0] tx_sel;

    int checks = 0;
    int errors = 0;
    int txl_cnt = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int viol = 0;
    logic prev_txl = 1'b0;
    logic prev_oe = 1'b0;
    logic [7:0] rx_q [$];
    vec_t tbl [8];

    always #5 clk = ~clk;

    i2c_target_if bus ();

    assign sda_line    = sda_m & ~bus.sda_oe;
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_line;
    assign tx_sel      = 2'(tx_done - tx_base);
    assign bus.tx_data = tx_arr[tx_sel];

    i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.rx_valid) rx_q.push_back(bus.rx_data);
        if (bus.tx_load) txl_cnt++;
        if (prev_txl && !bus.tx_load) tx_done++;
        if (bus.start_det) start_cnt++;
        if (bus.stop_det) stop_cnt++;
        if (mon_en && scl_m && (bus.sda_oe !== prev_oe)) viol++;
        prev_txl = bus.tx_load;
        prev_oe  = bus.sda_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic xfer_bit(input logic b, output logic seen);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait();
        seen = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
        xfer_bit(1'b1, s);
        ack = (s == I2C_ACK);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        xfer_bit(nack, s);
    endtask

    // Expected behaviour straight from the addressing rules.
    function automatic vec_t model(input logic [7:0] addr, input logic [7:0] b0,
                                   input logic [7:0] b1, input int n);
        vec_t v;
        logic hit;
        hit       = (addr[7:1] == 7'h42);
        v.addr    = addr;
        v.b0      = b0;
        v.b1      = b1;
        v.n       = n;
        v.exp_ack = hit;
        if (!addr[0]) begin
            v.exp_rx  = hit ? n : 0;
            v.exp_txl = 0;
            v.exp_r0  = b0;
            v.exp_r1  = b1;
        end else begin
            v.exp_rx  = 0;
            v.exp_txl = hit ? n : 0;
            v.exp_r0  = hit ? b0 : 8'hFF;
            v.exp_r1  = hit ? b1 : 8'hFF;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int         rx0, txl0, st0, sp0;
        logic       ack, all_ack;
        logic [7:0] d;
        logic [7:0] got [2];
        got[0]  = 8'h00;
        got[1]  = 8'h00;
        tx_arr[0] = v.b0;
        tx_arr[1] = v.b1;
        tx_base = tx_done;
        rx0  = rx_q.size();
        txl0 = txl_cnt;
        st0  = start_cnt;
        sp0  = stop_cnt;
        all_ack = 1'b1;

        i2c_start();
        send_byte(v.addr, ack);
        check($sformatf("addr_ack[%02h]", v.addr), 32'(ack), 32'(v.exp_ack));
        check($sformatf("busy_after_addr[%02h]", v.addr), 32'(bus.busy), 32'(v.exp_ack));
        for (int i = 0; i < v.n; i++) begin
            if (!v.addr[0]) begin
                send_byte((i == 0) ? v.b0 : v.b1, ack);
                if (ack !== v.exp_ack) all_ack = 1'b0;
            end else begin
                recv_byte(i == v.n - 1, d);
                got[i] = d;
            end
        end
        if (!v.addr[0]) begin
            check("data_ack", 32'(all_ack), 32'd1);
        end else begin
            check("rd_byte0", 32'(got[0]), 32'(v.exp_r0));
            if (v.n > 1) check("rd_byte1", 32'(got[1]), 32'(v.exp_r1));
            if (v.exp_ack) begin
                check("state_after_nack", 32'(dut.state == ST_WAIT_STOP), 32'd1);
                check("oe_after_nack", 32'(bus.sda_oe), 32'd0);
            end
        end
        i2c_stop();

        check("rx_count", 32'(rx_q.size() - rx0), 32'(v.exp_rx));
        for (int i = 0; i < v.exp_rx; i++) begin
            if (rx_q.size() > rx0 + i)
                check($sformatf("rx_byte%0d", i), 32'(rx_q[rx0 + i]),
                      32'((i == 0) ? v.exp_r0 : v.exp_r1));
        end
        check("tx_load_count", 32'(txl_cnt - txl0), 32'(v.exp_txl));
        check("start_count", 32'(start_cnt - st0), 32'd1);
        check("stop_count", 32'(stop_cnt - sp0), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("oe_end", 32'(bus.sda_oe), 32'd0);
    endtask

    initial begin
        logic       a1, a2, a3, s;
        logic [7:0] d;
        logic [6:0] a7;
        int         rx0, txl0, st0, sp0;

        tx_arr[0] = 8'h00; tx_arr[1] = 8'h00; tx_arr[2] = 8'h00; tx_arr[3] = 8'h00;

        tbl[0] = '{8'h84, 8'hA5, 8'h00, 1, 1'b1, 1, 0, 8'hA5, 8'h00};
        tbl[1] = '{8'h86, 8'hFF, 8'h00, 1, 1'b0, 0, 0, 8'hFF, 8'h00};
        tbl[2] = '{8'h85, 8'h3C, 8'h00, 1, 1'b1, 0, 1, 8'h3C, 8'h00};
        tbl[3] = '{8'h85, 8'h3C, 8'hC3, 2, 1'b1, 0, 2, 8'h3C, 8'hC3};
        tbl[4] = '{8'h00, 8'h55, 8'h00, 1, 1'b0, 0, 0, 8'h55, 8'h00};
        tbl[5] = '{8'hF0, 8'h11, 8'h00, 1, 1'b0, 0, 0, 8'h11, 8'h00};
        tbl[6] = '{8'h84, 8'h00, 8'hFF, 2, 1'b1, 2, 0, 8'h00, 8'hFF};
        tbl[7] = '{8'h87, 8'h99, 8'h00, 1, 1'b0, 0, 0, 8'hFF, 8'h00};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_load", 32'(bus.tx_load), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start_det", 32'(bus.start_det), 32'd0);
        check("rst_stop_det", 32'(bus.stop_det), 32'd0);
        check("rst_state", 32'(dut.state == ST_IDLE), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Repeated START: write 0x11, then Sr and a one-byte read
        tx_arr[0] = 8'h3C;
        tx_base = tx_done;
        rx0  = rx_q.size();
        txl0 = txl_cnt;
        st0  = start_cnt;
        sp0  = stop_cnt;
        i2c_start();
        send_byte(8'h84, a1);
        send_byte(8'h11, a2);
        i2c_start();
        send_byte(8'h85, a3);
        recv_byte(1'b1, d);
        i2c_stop();
        check("sr_acks", 32'({a1, a2, a3}), 32'h7);
        check("sr_rx_count", 32'(rx_q.size() - rx0), 32'd1);
        if (rx_q.size() > rx0) check("sr_rx_byte", 32'(rx_q[rx0]), 32'h11);
        check("sr_start_count", 32'(start_cnt - st0), 32'd2);
        check("sr_stop_count", 32'(stop_cnt - sp0), 32'd1);
        check("sr_tx_load", 32'(txl_cnt - txl0), 32'd1);
        check("sr_rd_byte", 32'(d), 32'h3C);

        // Reset while the target pulls SDA low for bit 5 of 0xC3
        tx_arr[0] = 8'hC3;
        tx_base = tx_done;
        i2c_start();
        send_byte(8'h85, a1);
        check("mr_addr_ack", 32'(a1), 32'd1);
        xfer_bit(1'b1, s);
        xfer_bit(1'b1, s);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        check("mr_bit5_driven", 32'(bus.sda_oe), 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_oe_released", 32'(bus.sda_oe), 32'd0);
        check("mr_state_idle", 32'(dut.state == ST_IDLE), 32'd1);
        check("mr_busy", 32'(bus.busy), 32'd0);
        qwait();
        scl_m = 1'b0; qwait();
        mon_en = 1'b1;
        run_vec(model(8'h84, 8'h5A, 8'h00, 1));

        // Randomized transfers against the model
        for (int k = 0; k < 14; k++) begin
            a7 = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom);
            run_vec(model({a7, 1'($urandom)}, 8'($urandom), 8'($urandom),
                          int'($urandom_range(1, 2))));
        end

        check("oe_change_while_scl_high", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers the existing I2C master controller on the same SDA/SCL pair.
- Runs on the system clock, oversamples SCL/SDA, and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, and moves data bytes in both directions:
  - write: bytes flow from the bus to the core as rx_data/rx_valid.
  - read: bytes flow from the core to the bus via tx_data/tx_load.
- Open-drain only: it never drives SDA high and never drives or stretches SCL.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop stages in the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥16× the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  SCL pin level (asynchronous).
- sda_in  input  1  SDA pin level (asynchronous).
- sda_oe  output  1  1 pulls SDA low; 0 releases it (pad is open-drain).
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  input  8  byte to return on a read; sampled when tx_load=1.
- tx_load  output  1  one-cycle pulse; tx_data is captured in that cycle.
- busy  output  1  high from an address match until STOP, address mismatch or master NACK.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, start_det=0, stop_det=0.
  - Synchroniser flops to 1 (idle-high bus).
  - Reset mid-transfer releases SDA on the same edge.
- Input path and edge detection:
  - Each pin passes through SYNC_STAGES flops, then one history flop.
  - scl_rise/scl_fall are decoded from the synchronised and history bits, so edges are seen SYNC_STAGES+1 clocks after the pin change.
  - START = SDA falls while synchronised SCL=1. STOP = SDA rises while synchronised SCL=1.
- Bit timing:
  - Data is sampled on scl_rise.
  - sda_oe changes only in the cycle after scl_fall, so SDA is never changed while SCL is high.
- State machine: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - START from any state → ADDR; bit counter=7, sda_oe=0. A START has priority over the decoded bit.
  - STOP from any state → IDLE; sda_oe=0, busy=0.
  - ADDR: shift 8 bits MSB first. After the 8th rise:
    - if shift[7:1]==TARGET_ADDR → ADDR_ACK, busy=1;
    - otherwise → WAIT_STOP, SDA stays released.
  - ADDR_ACK: drive SDA low for the 9th clock.
    - At the fall that ends the ACK: R/W=0 → WR_DATA.
    - R/W=1 → RD_DATA; tx_load pulses and tx_data is captured into the shift register in that same cycle, then bit 7 is driven.
  - WR_DATA: after the 8th rise, rx_data is updated and rx_valid pulses once → WR_ACK.
  - WR_ACK: always ACK (drive low for the 9th clock) → WR_DATA. Unlimited byte count.
  - RD_DATA: for each bit, sda_oe = ~shift[7]; shift left at each fall. After the 8th fall, release SDA → RD_ACK.
  - RD_ACK: sample SDA at the 9th rise.
    - 0 (master ACK) → tx_load pulses at the following fall, next byte → RD_DATA.
    - 1 (NACK) → WAIT_STOP, busy=0.
  - WAIT_STOP: ignore SCL; wait for START or STOP.
- Width and counters: 3-bit down counter, wraps 0→7 on byte completion. 8-bit shift register.
- Out of scope: general call and 10-bit addressing (ignored, treated as mismatch), clock stretching.
- A STOP or START arriving between bits discards any partial byte; no rx_valid is generated for it.

Decomposition:
- Shared package/header i2c_pkg: state encodings, I2C_ACK=0 and I2C_NACK=1, RW_BIT index 0, ADDR_WIDTH=7. The master controller uses the same constants.
- One sub-module, i2c_sync_edge: an N-stage synchroniser plus history flop producing level, rise and fall. It is instantiated once for SCL and once for SDA.

Test Plan:
- Write one byte: START, 0x84 (0x42 + W), 0xA5, STOP → sda_oe=1 during both 9th clocks; rx_valid pulses once with rx_data=0xA5; stop_det pulses; busy returns to 0.
- Read with NACK: tx_data=0x3C; START, 0x85 → address ACK, tx_load pulse; SDA shows 0,0,1,1,1,1,0,0; master NACKs → sda_oe=0, state WAIT_STOP.
- Two-byte read with ACK: tx_data changes from 0x3C to 0xC3 after the first tx_load; master ACKs byte 1 → second tx_load pulse; byte 2 on SDA is 0xC3.
- Address mismatch: START, 0x86 (addr 0x43), data 0xFF → sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Repeated START: write 0x84, 0x11, then Sr + 0x85 → rx_valid for 0x11 only; start_det pulses twice; read phase begins with tx_load.
- Reset mid-read while bit 5 is driven low: assert rst for 1 clk → sda_oe=0 on that edge; state IDLE; a following normal write of 0x5A still gives rx_data=0x5A.
